// File: rtl/sprite_rom_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_rom_arbiter_if
//  Description : Bundle of requester-side and ROM-side signals for the shared
//                sprite ROM arbiter. The arbiter connects through the slave
//                modport; requesters and ROM model connect through master.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sprite_rom_arbiter_if #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 24
);
    // Requester side
    logic [N_REQ-1:0]        req;
    logic [N_REQ*ADDR_W-1:0] addr;
    logic [N_REQ-1:0]        gnt;
    logic [DATA_W-1:0]       rdata;
    logic [N_REQ-1:0]        rdata_valid;

    // ROM side
    logic [ADDR_W-1:0]       rom_addr;
    logic                    rom_rd;
    logic [DATA_W-1:0]       rom_q;

    modport slave (
        input  req, addr, rom_q,
        output gnt, rdata, rdata_valid, rom_addr, rom_rd
    );

    modport master (
        output req, addr, rom_q,
        input  gnt, rdata, rdata_valid, rom_addr, rom_rd
    );
endinterface
`default_nettype wire

// File: rtl/sprite_rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_rom_arbiter
//  Description : Shares one single-port sprite ROM among N_REQ requesters.
//                One requester is granted per cycle (round-robin), its
//                address is driven to the ROM, and the ROM word is returned
//                ROM_LAT+1 cycles later tagged with a one-hot owner valid.
//  Options     : SPRITE_ARB_PRIO0_EN - when defined, requester 0 has strict
//                priority and the remaining requesters round-robin among
//                themselves in cycles where requester 0 is idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_rom_arbiter #(
    parameter int N_REQ   = 3,   // 2..8
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 24,
    parameter int ROM_LAT = 2    // 1..4
) (
    input  wire                   Clk,
    input  wire                   Reset_n,
    sprite_rom_arbiter_if.slave   bus
);

    localparam int c_PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [c_PTR_W-1:0] c_PTR_RST = c_PTR_W'(N_REQ - 1);

    // Round-robin pointer: index of the most recently granted requester.
    logic [c_PTR_W-1:0] r_rr_ptr;

    // Arbitration results
    logic [N_REQ-1:0]   w_gnt;
    logic               w_any;
    logic [c_PTR_W-1:0] w_gnt_idx;
    logic               w_ptr_upd;
    logic [c_PTR_W-1:0] w_cand;
    logic [ADDR_W-1:0]  w_rom_addr;

    // Owner tag pipeline aligned with the ROM read latency
    logic               r_tag_v  [ROM_LAT];
    logic [N_REQ-1:0]   r_tag_oh [ROM_LAT];

    // Response registers
    logic [DATA_W-1:0]  r_rdata;
    logic [N_REQ-1:0]   r_rdata_valid;

    // Candidate index ptr+step, wrapped into 0..N_REQ-1
    function automatic logic [c_PTR_W-1:0] f_rr_idx(
        input logic [c_PTR_W-1:0] ptr,
        input int                 step
    );
        int v;
        v = (int'(ptr) + step) % N_REQ;
        return c_PTR_W'(v);
    endfunction

    // Grant selection: first asserted request searching from rr_ptr+1
    always_comb begin
        w_gnt     = '0;
        w_any     = 1'b0;
        w_gnt_idx = '0;
        w_ptr_upd = 1'b0;
        w_cand    = '0;
`ifdef SPRITE_ARB_PRIO0_EN
        // Pixel-path lookup is deadline critical: it always wins and does
        // not disturb the rotation among the other requesters.
        if (bus.req[0]) begin
            w_gnt[0]  = 1'b1;
            w_any     = 1'b1;
            w_gnt_idx = '0;
        end else begin
            for (int k = 1; k <= N_REQ; k++) begin
                w_cand = f_rr_idx(r_rr_ptr, k);
                if (!w_any && (w_cand != '0) && bus.req[w_cand]) begin
                    w_gnt[w_cand] = 1'b1;
                    w_any         = 1'b1;
                    w_gnt_idx     = w_cand;
                    w_ptr_upd     = 1'b1;
                end
            end
        end
`else
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = f_rr_idx(r_rr_ptr, k);
            if (!w_any && bus.req[w_cand]) begin
                w_gnt[w_cand] = 1'b1;
                w_any         = 1'b1;
                w_gnt_idx     = w_cand;
                w_ptr_upd     = 1'b1;
            end
        end
`endif
        // Nothing is granted or driven to the ROM while reset is held.
        if (!Reset_n) begin
            w_gnt     = '0;
            w_any     = 1'b0;
            w_ptr_upd = 1'b0;
        end
    end

    // ROM address mux from the one-hot grant; zero when idle
    always_comb begin
        w_rom_addr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) begin
                w_rom_addr = bus.addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Round-robin pointer follows the granted index
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rr_ptr <= c_PTR_RST;
        end else if (w_ptr_upd) begin
            r_rr_ptr <= w_gnt_idx;
        end
    end

    // Owner tag shift register: stage ROM_LAT-1 lines up with rom_q
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int s = 0; s < ROM_LAT; s++) begin
                r_tag_v[s]  <= 1'b0;
                r_tag_oh[s] <= '0;
            end
        end else begin
            r_tag_v[0]  <= w_any;
            r_tag_oh[0] <= w_gnt;
            for (int s = 1; s < ROM_LAT; s++) begin
                r_tag_v[s]  <= r_tag_v[s-1];
                r_tag_oh[s] <= r_tag_oh[s-1];
            end
        end
    end

    // Capture ROM word for its owner; data holds when no response
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rdata       <= '0;
            r_rdata_valid <= '0;
        end else if (r_tag_v[ROM_LAT-1]) begin
            r_rdata       <= bus.rom_q;
            r_rdata_valid <= r_tag_oh[ROM_LAT-1];
        end else begin
            r_rdata_valid <= '0;
        end
    end

    assign bus.gnt         = w_gnt;
    assign bus.rom_rd      = w_any;
    assign bus.rom_addr    = w_rom_addr;
    assign bus.rdata       = r_rdata;
    assign bus.rdata_valid = r_rdata_valid;

endmodule
`default_nettype wire

// File: tb/tb_sprite_rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sprite_rom_arbiter
//  Description : Self-checking bench for sprite_rom_arbiter. Directed
//                scenarios followed by random request traffic, compared
//                against a behavioural arbiter/scoreboard model and a ROM
//                model whose word is address+1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_rom_arbiter;

    localparam int N   = 3;
    localparam int AW  = 16;
    localparam int DW  = 24;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    sprite_rom_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    sprite_rom_arbiter #(
        .N_REQ  (N),
        .ADDR_W (AW),
        .DATA_W (DW),
        .ROM_LAT(LAT)
    ) u_dut (
        .Clk    (clk),
        .Reset_n(rst_n),
        .bus    (bus)
    );

    // ROM model: samples the address each edge, word = address + 1
    logic [AW-1:0] rom_pipe [LAT];
    always @(posedge clk) begin
        rom_pipe[0] <= bus.rom_addr;
        for (int s = 1; s < LAT; s++) rom_pipe[s] <= rom_pipe[s-1];
    end
    assign bus.rom_q = DW'(rom_pipe[LAT-1]) + DW'(1);

    // Scoreboard of expected responses in grant order
    typedef struct {
        int            owner;
        logic [DW-1:0] data;
        int            due;
    } resp_t;
    resp_t sb_q[$];

    int            n_total = 0;
    int            n_bad   = 0;
    int            cyc     = 0;
    int            m_last  = N - 1;   // most recently granted requester
    int            last_w  = -1;      // requester granted in previous step
    logic [DW-1:0] m_rdata = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: check outputs at negedge against the model, then
    // advance to just after the next rising edge.
    task automatic step();
        int            w;
        int            idx;
        logic [N-1:0]  exp_gnt;
        logic [N-1:0]  exp_v;
        logic [AW-1:0] exp_a;
        resp_t         r;
        @(negedge clk);
        w = -1;
        if (!rst_n) begin
            sb_q.delete();
            m_rdata = '0;
            m_last  = N - 1;
        end else begin
`ifdef SPRITE_ARB_PRIO0_EN
            if (bus.req[0]) begin
                w = 0;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    idx = (m_last + k) % N;
                    if (w < 0 && idx != 0 && bus.req[idx]) w = idx;
                end
            end
`else
            for (int k = 1; k <= N; k++) begin
                idx = (m_last + k) % N;
                if (w < 0 && bus.req[idx]) w = idx;
            end
`endif
        end
        exp_gnt = '0;
        exp_a   = '0;
        if (w >= 0) begin
            exp_gnt[w] = 1'b1;
            exp_a      = bus.addr[w*AW +: AW];
        end
        chk("gnt", 64'(bus.gnt), 64'(exp_gnt));
        chk("rom_rd", 64'(bus.rom_rd), 64'(w >= 0));
        chk("rom_addr", 64'(bus.rom_addr), 64'(exp_a));

        exp_v = '0;
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            r = sb_q.pop_front();
            exp_v[r.owner] = 1'b1;
            m_rdata = r.data;
        end
        chk("rdata_valid", 64'(bus.rdata_valid), 64'(exp_v));
        chk("rdata", 64'(bus.rdata), 64'(m_rdata));

        if (w >= 0) begin
            r.owner = w;
            r.data  = DW'(exp_a) + DW'(1);
            r.due   = cyc + LAT + 1;
            sb_q.push_back(r);
`ifdef SPRITE_ARB_PRIO0_EN
            if (w != 0) m_last = w;
`else
            m_last = w;
`endif
        end
        last_w = w;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        bus.req = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        bus.req  = '0;
        bus.addr = '0;
        rst_n    = 1'b1;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;

        // Reset held with requests pending: nothing granted
        bus.req = 3'b111;
        bus.addr = {16'h3333, 16'h2222, 16'h1111};
        step();
        step();
        rst_n = 1'b1;

        // Single request from requester 0
        bus.req = 3'b001;
        bus.addr[0*AW +: AW] = 16'h0010;
        step();
        idle(4);

        // All requesters, addresses bump per grant
        bus.req = 3'b111;
        bus.addr = {16'h0300, 16'h0200, 16'h0100};
        for (int i = 0; i < 6; i++) begin
            step();
            if (last_w >= 0) bus.addr[last_w*AW +: AW] = bus.addr[last_w*AW +: AW] + 16'd1;
        end
        idle(4);

        // Sole requester 1 streaming addresses 0..7
        bus.req = 3'b010;
        bus.addr[1*AW +: AW] = 16'd0;
        for (int i = 0; i < 8; i++) begin
            step();
            bus.addr[1*AW +: AW] = bus.addr[1*AW +: AW] + 16'd1;
        end
        idle(4);

        // Grant to 2, then 1 and 2 compete, then 0 joins (pointer wrap)
        bus.req = 3'b100;
        step();
        bus.req = 3'b110;
        step();
        step();
        bus.req = 3'b111;
        for (int i = 0; i < 4; i++) step();
        idle(4);

        // Prio scenario traffic (pure round-robin in the default build)
        bus.req = 3'b111;
        for (int i = 0; i < 4; i++) step();
        bus.req = 3'b110;
        for (int i = 0; i < 4; i++) step();

        // Reset with two responses in flight
        bus.req = 3'b111;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        idle(5);
        bus.req = 3'b011;
        step();
        idle(4);

        // Random traffic obeying the hold-until-grant handshake
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (bus.req[i] && last_w == i) begin
                    bus.addr[i*AW +: AW] = AW'($urandom);
                    bus.req[i] = ($urandom_range(0, 3) != 0);
                end else if (bus.req[i]) begin
                    if ($urandom_range(0, 9) == 0) bus.req[i] = 1'b0;
                end else begin
                    bus.req[i] = $urandom_range(0, 1) != 0;
                    bus.addr[i*AW +: AW] = AW'($urandom);
                end
            end
            step();
        end
        idle(6);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares one single-port sprite ROM (duck, dog, crosshair and background art) among N_REQ sprite/pixel requesters on the Clk domain.
- Each requester issues a req/addr pair. The block grants one requester per cycle using round-robin and drives the ROM address. It then returns the ROM word, tagged with a per-requester valid, after a fixed latency.
- It sits between the sprite modules (duck, color mapper lookups) and the ROM instance, replacing each module's private ROM copy.

Parameters:
- N_REQ, 3, number of requesters (2..8)
- ADDR_W, 16, ROM address width
- DATA_W, 24, ROM word width (RGB888)
- ROM_LAT, 2, ROM read latency in cycles, from address sampled to rom_q valid (1..4)

Ports:
- Clk  in  1  system clock (50 MHz)
- Reset_n  in  1  asynchronous active-low reset
- req  in  N_REQ  per-requester read request, level
- addr  in  N_REQ*ADDR_W  packed addresses; requester i uses addr[i*ADDR_W +: ADDR_W]
- gnt  out  N_REQ  one-hot grant, combinational, same cycle as acceptance
- rdata  out  DATA_W  registered read data, shared by all requesters
- rdata_valid  out  N_REQ  one-hot, registered; marks the owner of rdata
- rom_addr  out  ADDR_W  ROM address, combinational from the granted requester
- rom_rd  out  1  ROM read strobe, equals |gnt
- rom_q  in  DATA_W  ROM output data

Behaviour:
- Reset (Reset_n=0, async):
  - rr_ptr = N_REQ-1, so requester 0 has first priority after reset.
  - Tag/valid pipeline cleared; rdata=0; rdata_valid=0.
  - gnt=0, rom_rd=0 and rom_addr=0 while reset is held.
- Handshake:
  - A requester holds req=1 with addr stable until it sees gnt=1.
  - A request is accepted in the cycle where req[i]&gnt[i]=1.
  - A requester may keep req high for back-to-back reads, changing addr after each accepted cycle.
  - Dropping req before grant is allowed; the request is then simply not served.
- Arbitration:
  - At most one gnt bit per cycle; gnt=0 when req=0.
  - Search order is rr_ptr+1, rr_ptr+2, … mod N_REQ. The first asserted req wins.
  - rr_ptr takes the granted index at the clock edge; it is unchanged in cycles with no grant.
  - A sole requester is granted every cycle, giving 100% throughput.
- Datapath:
  - rom_addr = addr of the granted requester; 0 when there is no grant.
  - A tag pipeline of depth ROM_LAT carries a one-hot owner and a valid bit.
  - In the cycle after stage ROM_LAT: rdata <= rom_q and rdata_valid <= the owner one-hot.
  - Total latency: a grant in cycle T gives rdata_valid in cycle T+ROM_LAT+1.
  - rdata holds its last value when rdata_valid=0.
- Ordering: responses return in grant order with no reordering. One response per accepted request, none lost.
- Boundaries:
  - All requesters asserted: each is granted once in every N_REQ consecutive cycles.
  - Reset asserted mid-flight: all in-flight responses are discarded, with no rdata_valid after reset release.
  - A req that rises in the same cycle as another requester's grant is considered next cycle.
  - addr values are used as given, with no range check; they wrap within ADDR_W.

Optional Feature:
- Macro: SPRITE_ARB_PRIO0_EN
- Defined: requester 0 (pixel-path color lookup, which is deadline critical) has strict priority. If req[0]=1 it is granted regardless of rr_ptr, and rr_ptr is not updated. The other requesters round-robin among themselves only in cycles with req[0]=0.
- Undefined: pure round-robin over all N_REQ requesters, as described above.

Test Plan:
- Reset release, req=3'b001, addr0=16'h0010, ROM returns addr+1 -> gnt=001 in cycle T; rdata_valid=001 and rdata=24'h000011 at T+3 (ROM_LAT=2).
- req=3'b111 held for 6 cycles with addresses incrementing per grant -> gnt sequence 001,010,100,001,010,100. rdata_valid follows the same sequence 3 cycles later, with matching data.
- req1 only, held 8 cycles with addr 0..7 -> gnt[1]=1 every cycle; 8 consecutive rdata_valid=010 carrying data 1..8, in order.
- req=3'b110 after a grant to 2 -> next grant is to 1, then 2. rr_ptr wraps from 2 to 0 correctly when req0 joins.
- Two grants in flight, then Reset_n=0 for 1 cycle -> rdata_valid stays 0 for 5 cycles after release; the first new request is granted to requester 0.
- With SPRITE_ARB_PRIO0_EN and req=3'b111 for 4 cycles -> gnt=001 all 4 cycles. Then req=3'b110 -> gnt alternates 010,100.
